// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared definitions for the register-file write arbiter and its FIFO.
//   REG_W / DATA_W : register-number and data widths of the 32x32 register file
//   ZERO_REG       : architectural zero register; writes to it are discarded
//   wr_req_t       : one write request {destination, value}
//   win_src_e      : which requester owns the write port in a given cycle
//   req_live()     : a request that actually has to reach the register file
// -----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_FORCE  = 3'd1,
        SRC_WB     = 3'd2,
        SRC_HEAD   = 3'd3,
        SRC_BYPASS = 3'd4
    } win_src_e;

    // A request to r0 is accepted by the handshake but otherwise behaves as
    // if it never happened.
    function automatic logic req_live(input logic v, input logic [REG_W-1:0] r);
        return v && (r != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// -----------------------------------------------------------------------------
// wr_fifo
// DEPTH-entry circular FIFO holding long-latency write requests that lost
// arbitration. Also presents every entry in age order (index 0 = head/oldest)
// so the top can run the forwarding lookup over uncommitted values.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_push         : enqueue i_push_req at the tail
//   i_pop          : dequeue the head
//   o_head         : current head entry (valid when !o_empty)
//   o_empty/o_full : occupancy flags from the registered count
//   o_age_req/vld  : all entries ordered oldest..youngest with valid bits
// Simultaneous push and pop leave the count unchanged; both pointers advance
// and wrap modulo DEPTH (DEPTH must be a power of two).
// -----------------------------------------------------------------------------
module wr_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  wr_req_t               i_push_req,
    input  logic                  i_pop,
    output wr_req_t               o_head,
    output logic                  o_empty,
    output logic                  o_full,
    output wr_req_t [DEPTH-1:0]   o_age_req,
    output logic    [DEPTH-1:0]   o_age_vld
);

    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    wr_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_DEPTH);

    // Defensive gating: an illegal push/pop is dropped rather than corrupting
    // the count.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is defined purely by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_req;
    end

    assign o_head = r_mem[r_rd_ptr];

    // Pointer arithmetic wraps naturally at PTR_W bits.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_age_req[i] = r_mem[r_rd_ptr + PTR_W'(i)];
            o_age_vld[i] = (CNT_W'(i) < r_count);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the single write port of the 32x32 register file. Merges WB-stage
// results with long-latency (mul/div, load-miss) results, queueing the latter
// in wr_fifo, and registers the winning write onto write_reg/write_data/reg_w.
//
// Ports
//   clk, reset            : clock; asynchronous active-high reset
//   wb_valid/reg/data     : WB request; wb_stall=1 means it was refused and
//                           the pipeline re-presents it next cycle
//   lu_valid/reg/data     : long-latency result; lu_ready accepts it
//   write_reg/data, reg_w : registered write port to the register file
//   q_reg -> q_hit/q_data : combinational lookup of uncommitted values
//
// Handshake: an lu result transfers in any cycle where lu_valid && lu_ready.
// lu_ready depends only on the registered FIFO count, so a full FIFO refuses
// even in a cycle where its head drains. A WB request is taken in any cycle
// with wb_valid && !wb_stall; wb_stall depends only on registered state.
//
// Winner each cycle: forced head (guard build) > WB > FIFO head > lu bypass
// (bypass only with an empty FIFO, so lu results never overtake the queue).
// Requests to r0 are accepted and dropped.
//
// Build option: define WB_STARVE_GUARD_EN to add the starvation guard. The
// head's waiting age is counted and, at STARVE_MAX, the head is forced out
// while WB is stalled for that one cycle. Without it, wb_stall is constant 0
// and a continuously busy WB stage can starve the queue.
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_W-1:0]  lu_reg,
    input  logic [DATA_W-1:0] lu_data,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_w,
    input  logic [REG_W-1:0]  q_reg,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data
);

    wr_req_t              w_wb_req;
    wr_req_t              w_lu_req;
    wr_req_t              w_head;
    wr_req_t              w_win_req;
    wr_req_t [DEPTH-1:0]  w_age_req;
    logic    [DEPTH-1:0]  w_age_vld;
    win_src_e             w_src;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_force;
    logic w_wb_live;
    logic w_lu_live;

    wr_req_t r_out;
    logic    r_reg_w;

    assign w_wb_req = '{rd: wb_reg, data: wb_data};
    assign w_lu_req = '{rd: lu_reg, data: lu_data};

    assign lu_ready  = !w_full;
    assign w_wb_live = req_live(wb_valid && !wb_stall, wb_reg);
    assign w_lu_live = req_live(lu_valid && lu_ready, lu_reg);

    // ---------------------------------------------------------------------
    // Starvation guard
    // ---------------------------------------------------------------------
`ifdef WB_STARVE_GUARD_EN
    localparam int AGE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    logic [AGE_W-1:0] r_age;

    assign w_force = !w_empty && (r_age == AGE_MAX);

    // Age counts cycles the current head sat without leaving. Reaching
    // AGE_MAX forces a pop, so the counter never runs past it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_age <= '0;
        end else if (w_empty || w_pop) begin
            r_age <= '0;
        end else begin
            r_age <= r_age + 1'b1;
        end
    end
`else
    logic w_unused_starve;

    assign w_force         = 1'b0;
    assign w_unused_starve = (STARVE_MAX != 0);
`endif

    assign wb_stall = w_force;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    always_comb begin
        w_src     = SRC_NONE;
        w_win_req = '0;
        w_pop     = 1'b0;
        if (w_force) begin
            w_src     = SRC_FORCE;
            w_win_req = w_head;
            w_pop     = 1'b1;
        end else if (w_wb_live) begin
            w_src     = SRC_WB;
            w_win_req = w_wb_req;
        end else if (!w_empty) begin
            w_src     = SRC_HEAD;
            w_win_req = w_head;
            w_pop     = 1'b1;
        end else if (w_lu_live) begin
            w_src     = SRC_BYPASS;
            w_win_req = w_lu_req;
        end
    end

    // An accepted lu result that did not go straight to the port joins the
    // tail. lu_ready already guarantees there is room.
    assign w_push = w_lu_live && (w_src != SRC_BYPASS);

    wr_fifo #(
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_push     (w_push),
        .i_push_req (w_lu_req),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_age_req  (w_age_req),
        .o_age_vld  (w_age_vld)
    );

    // ---------------------------------------------------------------------
    // Output register: zero payload when nobody wins keeps the port quiet.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= '0;
            r_reg_w <= 1'b0;
        end else begin
            r_out   <= w_win_req;
            r_reg_w <= (w_src != SRC_NONE);
        end
    end

    assign write_reg  = r_out.rd;
    assign write_data = r_out.data;
    assign reg_w      = r_reg_w;

    // ---------------------------------------------------------------------
    // Lookup: later assignments override earlier ones, so the output register
    // is checked first and the FIFO is scanned oldest to youngest, leaving the
    // youngest FIFO match as the result.
    // ---------------------------------------------------------------------
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (q_reg != ZERO_REG) begin
            if (r_reg_w && (r_out.rd == q_reg)) begin
                q_hit  = 1'b1;
                q_data = r_out.data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_age_vld[i] && (w_age_req[i].rd == q_reg)) begin
                    q_hit  = 1'b1;
                    q_data = w_age_req[i].data;
                end
            end
        end
    end

endmodule
